// File: rtl/bcd_display_mux_if.sv
// Value/handshake bundle between the calculator result path and the display multiplexer.
// The master drives the value and strobes; the slave returns the ack and the pin-level outputs.
interface bcd_display_mux_if;
    logic [15:0] bcd_in;
    logic        neg_in;
    logic        load;
    logic        blank_in;
    logic        load_ack;
    logic [3:0]  anodes;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output bcd_in, neg_in, load, blank_in,
        input  load_ack, anodes, seg, dp
    );

    modport slave (
        input  bcd_in, neg_in, load, blank_in,
        output load_ack, anodes, seg, dp
    );
endinterface

// File: rtl/bcd_display_mux.sv
// Time-multiplexes a staged 4-digit BCD value plus sign onto a common-anode 7-segment display.
// New values are committed only at frame boundaries so a frame never mixes old and new digits.
module bcd_display_mux #(
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input logic              clk,
    input logic              reset,
    bcd_display_mux_if.slave bus
);
    localparam int               CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_DARK  = 7'b1111111;
    localparam logic [6:0]       SEG_MINUS = 7'b0111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0000110;
        endcase
    endfunction

    logic [15:0]      stage_q, stage_d, shadow_q, shadow_d;
    logic             stage_neg_q, stage_neg_d, shadow_neg_q, shadow_neg_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       anodes_q, anodes_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             ack_q, ack_d;

    logic             terminal, commit;
    logic [3:0]       nz, sup, minus;
    logic [3:0]       nib;

    always_comb begin
        terminal     = (cnt_q == CNT_LAST);
        commit       = terminal && (idx_q == 2'd3) && pending_q;

        cnt_d        = terminal ? '0 : cnt_q + 1'b1;
        idx_d        = terminal ? idx_q + 2'd1 : idx_q;

        // Commit reads staging as held before this edge; a coincident load refills it.
        stage_d      = stage_q;
        stage_neg_d  = stage_neg_q;
        shadow_d     = shadow_q;
        shadow_neg_d = shadow_neg_q;
        pending_d    = pending_q;
        if (commit) begin
            shadow_d     = stage_q;
            shadow_neg_d = stage_neg_q;
            pending_d    = 1'b0;
        end
        if (bus.load) begin
            stage_d     = bus.bcd_in;
            stage_neg_d = bus.neg_in;
            pending_d   = 1'b1;
        end
        ack_d = commit;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nz[i] = (shadow_q[4*i +: 4] != 4'd0);
        end
        sup[3] = BLANK_LEADING && !nz[3];
        sup[2] = sup[3] && !nz[2];
        sup[1] = sup[2] && !nz[1];
        sup[0] = 1'b0;

        // The minus sits in the suppressed slot directly left of the first shown digit.
        minus[0] = 1'b0;
        for (int i = 1; i < 4; i++) begin
            minus[i] = shadow_neg_q && sup[i] && !sup[i-1];
        end

        nib = shadow_q[{idx_q, 2'b00} +: 4];

        anodes_d = 4'b1111;
        seg_d    = SEG_DARK;
        dp_d     = 1'b1;
        if (!bus.blank_in) begin
            anodes_d = ~(4'b0001 << idx_q);
            if (minus[idx_q])      seg_d = SEG_MINUS;
            else if (sup[idx_q])   seg_d = SEG_DARK;
            else                   seg_d = seg_decode(nib);
            dp_d = !(shadow_neg_q && !sup[3] && (idx_q == 2'd3));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_q      <= '0;
            stage_neg_q  <= 1'b0;
            shadow_q     <= '0;
            shadow_neg_q <= 1'b0;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            anodes_q     <= 4'b1111;
            seg_q        <= SEG_DARK;
            dp_q         <= 1'b1;
            ack_q        <= 1'b0;
        end else begin
            stage_q      <= stage_d;
            stage_neg_q  <= stage_neg_d;
            shadow_q     <= shadow_d;
            shadow_neg_q <= shadow_neg_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            anodes_q     <= anodes_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            ack_q        <= ack_d;
        end
    end

    assign bus.anodes   = anodes_q;
    assign bus.seg      = seg_q;
    assign bus.dp       = dp_q;
    assign bus.load_ack = ack_q;
endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: directed scenarios followed by random traffic, every cycle
// compared against a value-level model of what the display should show.
module tb_bcd_display_mux;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bcd_display_mux_if bus ();

    bcd_display_mux #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: what the display logically holds.
    int          m_cnt = 0, m_idx = 0;
    logic [15:0] m_stage = '0, m_shadow = '0;
    logic        m_sneg = 1'b0, m_neg = 1'b0, m_pend = 1'b0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_ack;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: glyph = 7'b1000000;  1: glyph = 7'b1111001;
            2: glyph = 7'b0100100;  3: glyph = 7'b0110000;
            4: glyph = 7'b0011001;  5: glyph = 7'b0010010;
            6: glyph = 7'b0000010;  7: glyph = 7'b1111000;
            8: glyph = 7'b0000000;  9: glyph = 7'b0010000;
            default: glyph = 7'b0000110;
        endcase
    endfunction

    task automatic step(input logic ld, input logic [15:0] b, input logic n,
                        input logic bl, input logic rn);
        int shown;
        int d;
        @(negedge clk);
        bus.load = ld; bus.bcd_in = b; bus.neg_in = n; bus.blank_in = bl; reset = rn;
        @(posedge clk);
        if (!rn) begin
            m_cnt = 0; m_idx = 0; m_stage = '0; m_shadow = '0;
            m_sneg = 0; m_neg = 0; m_pend = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ack = 1'b0;
        end else begin
            e_ack = (m_cnt == DIV-1) && (m_idx == 3) && m_pend;
            // Number of digits shown = position of the highest nonzero nibble + 1, at least 1.
            shown = 1;
            for (int i = 1; i < 4; i++) if ((m_shadow >> (4*i)) != 0) shown = i + 1;
            if (bl) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an = 4'hF & ~(4'(1) << m_idx);
                d = int'((m_shadow >> (4*m_idx)) & 16'hF);
                if (m_idx < shown)                    e_seg = glyph(d);
                else if (m_neg && m_idx == shown)     e_seg = 7'b0111111;
                else                                  e_seg = 7'h7F;
                e_dp = !(m_neg && shown == 4 && m_idx == 3);
            end
            if (e_ack) begin
                m_shadow = m_stage; m_neg = m_sneg; m_pend = 0;
            end
            if (ld) begin
                m_stage = b; m_sneg = n; m_pend = 1;
            end
            if (m_cnt == DIV-1) begin
                m_cnt = 0; m_idx = (m_idx + 1) % 4;
            end else m_cnt++;
        end
        #1;
        check_eq("anodes", 32'(bus.anodes), 32'(e_an));
        check_eq("seg", 32'(bus.seg), 32'(e_seg));
        check_eq("dp", 32'(bus.dp), 32'(e_dp));
        check_eq("load_ack", 32'(bus.load_ack), 32'(e_ack));
    endtask

    task automatic idle(input int n, input logic bl = 1'b0);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, bl, 1'b1);
    endtask

    task automatic load_val(input logic [15:0] b, input logic n);
        step(1'b1, b, n, 1'b0, 1'b1);
    endtask

    // Advance until the next edge is a frame boundary (bounded).
    task automatic align_boundary();
        int k = 0;
        while (!(m_cnt == DIV-1 && m_idx == 3) && k < 4*DIV + 2) begin
            idle(1);
            k++;
        end
        check_eq("align", 32'(m_cnt == DIV-1 && m_idx == 3), 32'd1);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v = '0;
        int lead = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] nib = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
            if (i < 4 - lead) v[4*i +: 4] = nib;
        end
        return v;
    endfunction

    initial begin
        logic bl_r = 1'b0;
        bus.load = 0; bus.bcd_in = '0; bus.neg_in = 0; bus.blank_in = 0;

        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        idle(20);

        idle(5);
        load_val(16'h1234, 1'b0);
        idle(40);

        load_val(16'h0042, 1'b1);
        idle(36);
        load_val(16'h9001, 1'b1);
        idle(40);

        load_val(16'h0001, 1'b0);
        idle(2);
        load_val(16'h0005, 1'b0);
        idle(40);

        load_val(16'h0007, 1'b0);
        align_boundary();
        load_val(16'h0008, 1'b1);
        idle(40);

        load_val(16'h00A3, 1'b0);
        idle(20);
        idle(10, 1'b1);
        idle(20);

        load_val(16'h0777, 1'b0);
        idle(3);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        idle(40);

        for (int c = 0; c < 3000; c++) begin
            logic ld = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 40) == 0) bl_r = ~bl_r;
            step(ld, rand_bcd(), 1'($urandom_range(0, 1)), bl_r,
                 ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
